mul_div_unit: RTL and testbench



---
 rtl/mul_div_unit_if.sv | 14 +
 rtl/mul_div_unit.sv | 93 +++++++++
 tb/tb_mul_div_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: start/done handshake and operand/result bus between control unit and mul_div_unit.
interface mul_div_unit_if #(parameter int WIDTH = 32) ();
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] zhi;
  logic [WIDTH-1:0] zlo;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  modport master (output start, op, a_in, b_in, input zhi, zlo, busy, done, div_by_zero);
  modport slave  (input start, op, a_in, b_in, output zhi, zlo, busy, done, div_by_zero);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative signed Booth multiplier / restoring divider feeding the Zhi/Zlo bus sources.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic          clock,
  input logic          clear,
  mul_div_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic               op_r;
  logic               a_neg;
  logic               b_neg;
  logic               b_zero;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   m;
  logic [2*WIDTH:0]   acc;
  logic [WIDTH:0]     hi_ext;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH:0]   booth_nxt;
  logic [2*WIDTH:0]   div_nxt;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic               last;
  assign last  = cnt == CNT_W'(WIDTH - 1);
  assign a_abs = bus.a_in[WIDTH-1] ? -bus.a_in : bus.a_in;
  assign b_abs = bus.b_in[WIDTH-1] ? -bus.b_in : bus.b_in;
  // Booth: the high half is widened by one bit so subtracting -2^(W-1) cannot overflow before the shift
  assign hi_ext    = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
  assign sum       = acc[1:0] == 2'b01 ? hi_ext + {m[WIDTH-1], m} :
                     acc[1:0] == 2'b10 ? hi_ext - {m[WIDTH-1], m} : hi_ext;
  assign booth_nxt = {sum, acc[WIDTH:1]};
  // Divide: acc holds {partial remainder (W+1 bits), dividend shifting out / quotient shifting in}
  assign shifted   = acc[2*WIDTH-1:WIDTH-1];
  assign diff      = shifted - {1'b0, m};
  assign div_nxt   = {diff[WIDTH] ? shifted : diff, acc[WIDTH-2:0], ~diff[WIDTH]};
  assign quo       = acc[WIDTH-1:0];
  assign rem       = acc[2*WIDTH-1:WIDTH];
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = bus.start ? RUN : IDLE;
      RUN:     state_n = last ? FINISH : RUN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state           <= IDLE;
      cnt             <= '0;
      op_r            <= 1'b0;
      a_neg           <= 1'b0;
      b_neg           <= 1'b0;
      b_zero          <= 1'b0;
      a_r             <= '0;
      m               <= '0;
      acc             <= '0;
      bus.zhi         <= '0;
      bus.zlo         <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else begin
      state    <= state_n;
      bus.busy <= state_n == RUN;
      bus.done <= state == FINISH;
      if (state == IDLE && bus.start) begin
        op_r            <= bus.op;
        a_neg           <= bus.a_in[WIDTH-1];
        b_neg           <= bus.b_in[WIDTH-1];
        b_zero          <= bus.b_in == '0;
        a_r             <= bus.a_in;
        m               <= bus.op ? b_abs : bus.a_in;
        acc             <= bus.op ? {{(WIDTH+1){1'b0}}, a_abs} : {{WIDTH{1'b0}}, bus.b_in, 1'b0};
        cnt             <= '0;
        bus.div_by_zero <= 1'b0;
      end else if (state == RUN) begin
        acc <= op_r ? div_nxt : booth_nxt;
        cnt <= cnt + 1'b1;
      end else if (state == FINISH) begin
        bus.zhi         <= !op_r ? acc[2*WIDTH:WIDTH+1] : b_zero ? a_r : a_neg ? -rem : rem;
        bus.zlo         <= !op_r ? acc[WIDTH:1] : b_zero ? '1 : (a_neg ^ b_neg) ? -quo : quo;
        bus.div_by_zero <= op_r & b_zero;
      end
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit, one task per scenario.
module tb_mul_div_unit;
  logic clock;
  logic clear;
  int   checks = 0;
  int   errors = 0;
  mul_div_unit_if #(.WIDTH(32)) bus ();
  mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (.clock(clock), .clear(clear), .bus(bus));
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end
  // called at a negedge; issues a start pulse across the next rising edge, returns at the following negedge
  task automatic launch(input logic op, input logic [31:0] a, input logic [31:0] b);
    bus.op    = op;
    bus.a_in  = a;
    bus.b_in  = b;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask
  // counts negedges until done; optionally disturbs inputs at cycle poke_n
  task automatic wait_done(input int poke_n, input logic poke_start, output int lat, output int bcnt);
    bcnt = int'(bus.busy);
    lat  = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clock);
      if (n == poke_n + 1) bus.start = 1'b0;
      if (bus.done) begin
        lat = n;
        break;
      end
      bcnt += int'(bus.busy);
      if (n == poke_n) begin
        bus.start = poke_start;
        bus.a_in  = 32'h1234_5678;
        bus.b_in  = 32'h0;
        bus.op    = ~bus.op;
      end
    end
  endtask
  task automatic test_reset;
    clear     = 1'b0;
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a_in  = 32'd5;
    bus.b_in  = 32'd5;
    repeat (3) @(negedge clock);
    checks += 5;
    if (bus.zhi !== 32'h0) begin errors++; $display("FAIL reset_zhi got %h want %h", bus.zhi, 32'h0); end
    if (bus.zlo !== 32'h0) begin errors++; $display("FAIL reset_zlo got %h want %h", bus.zlo, 32'h0); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got %b want 0", bus.div_by_zero); end
    bus.start = 1'b0;
    clear     = 1'b1;
    repeat (5) @(negedge clock);
    checks += 2;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", bus.busy); end
    if (bus.zlo !== 32'h0) begin errors++; $display("FAIL idle_zlo got %h want %h", bus.zlo, 32'h0); end
  endtask
  task automatic test_mul;
    int lat, bc;
    logic [31:0] va [3] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'd1000};
    logic [31:0] vb [3] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'd1000};
    logic [31:0] eh [3] = '{32'h4000_0000, 32'h3FFF_FFFF, 32'h0};
    logic [31:0] el [3] = '{32'h0000_0000, 32'h0000_0001, 32'h000F_4240};
    launch(1'b0, 32'hFFFF_FFF9, 32'd6);
    wait_done(0, 1'b0, lat, bc);
    checks += 5;
    if (lat !== 33) begin errors++; $display("FAIL mul_latency got %0d want 33", lat); end
    if (bc !== 32) begin errors++; $display("FAIL mul_busy_cycles got %0d want 32", bc); end
    if (bus.zhi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mul_zhi got %h want %h", bus.zhi, 32'hFFFF_FFFF); end
    if (bus.zlo !== 32'hFFFF_FFD6) begin errors++; $display("FAIL mul_zlo got %h want %h", bus.zlo, 32'hFFFF_FFD6); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL mul_busy_at_done got %b want 0", bus.busy); end
    @(negedge clock);
    checks += 2;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL mul_done_width got %b want 0", bus.done); end
    if (bus.zlo !== 32'hFFFF_FFD6) begin errors++; $display("FAIL mul_hold got %h want %h", bus.zlo, 32'hFFFF_FFD6); end
    for (int i = 0; i < 3; i++) begin
      launch(1'b0, va[i], vb[i]);
      wait_done(0, 1'b0, lat, bc);
      checks += 2;
      if (bus.zhi !== eh[i]) begin errors++; $display("FAIL mul_vec%0d_zhi got %h want %h", i, bus.zhi, eh[i]); end
      if (bus.zlo !== el[i]) begin errors++; $display("FAIL mul_vec%0d_zlo got %h want %h", i, bus.zlo, el[i]); end
    end
  endtask
  task automatic test_div;
    int lat, bc;
    logic [31:0] va [4] = '{32'hFFFF_FFEF, 32'h8000_0000, 32'd17, 32'd100};
    logic [31:0] vb [4] = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'd7};
    logic [31:0] eh [4] = '{32'hFFFF_FFFE, 32'h0, 32'd2, 32'd2};
    logic [31:0] el [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFD, 32'd14};
    for (int i = 0; i < 4; i++) begin
      launch(1'b1, va[i], vb[i]);
      wait_done(0, 1'b0, lat, bc);
      checks += 4;
      if (lat !== 33) begin errors++; $display("FAIL div_vec%0d_latency got %0d want 33", i, lat); end
      if (bus.zhi !== eh[i]) begin errors++; $display("FAIL div_vec%0d_zhi got %h want %h", i, bus.zhi, eh[i]); end
      if (bus.zlo !== el[i]) begin errors++; $display("FAIL div_vec%0d_zlo got %h want %h", i, bus.zlo, el[i]); end
      if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL div_vec%0d_dz got %b want 0", i, bus.div_by_zero); end
    end
  endtask
  task automatic test_div_by_zero;
    int lat, bc;
    launch(1'b1, 32'd1234, 32'd0);
    wait_done(0, 1'b0, lat, bc);
    checks += 4;
    if (lat !== 33) begin errors++; $display("FAIL dz_latency got %0d want 33", lat); end
    if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got %b want 1", bus.div_by_zero); end
    if (bus.zlo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_zlo got %h want %h", bus.zlo, 32'hFFFF_FFFF); end
    if (bus.zhi !== 32'd1234) begin errors++; $display("FAIL dz_zhi got %h want %h", bus.zhi, 32'd1234); end
    repeat (3) @(negedge clock);
    checks++;
    if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_sticky got %b want 1", bus.div_by_zero); end
    launch(1'b1, 32'd100, 32'd7);
    checks++;
    if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL dz_clear_on_start got %b want 0", bus.div_by_zero); end
    wait_done(0, 1'b0, lat, bc);
    checks++;
    if (bus.zlo !== 32'd14) begin errors++; $display("FAIL dz_followup_zlo got %h want %h", bus.zlo, 32'd14); end
  endtask
  task automatic test_ignore_start;
    int lat, bc;
    launch(1'b0, 32'd3, 32'd5);
    wait_done(10, 1'b1, lat, bc);
    checks += 4;
    if (lat !== 33) begin errors++; $display("FAIL ign_latency got %0d want 33", lat); end
    if (bus.zlo !== 32'd15) begin errors++; $display("FAIL ign_zlo got %h want %h", bus.zlo, 32'd15); end
    if (bus.zhi !== 32'd0) begin errors++; $display("FAIL ign_zhi got %h want %h", bus.zhi, 32'd0); end
    if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL ign_dz got %b want 0", bus.div_by_zero); end
    repeat (3) @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL ign_no_queue got %b want 0", bus.busy); end
  endtask
  task automatic test_operand_change;
    int lat, bc;
    launch(1'b1, 32'hFFFF_FF9C, 32'd7);
    wait_done(5, 1'b0, lat, bc);
    checks += 2;
    if (bus.zlo !== 32'hFFFF_FFF2) begin errors++; $display("FAIL opchg_zlo got %h want %h", bus.zlo, 32'hFFFF_FFF2); end
    if (bus.zhi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL opchg_zhi got %h want %h", bus.zhi, 32'hFFFF_FFFE); end
  endtask
  task automatic test_back_to_back;
    int lat1, lat2, bc;
    launch(1'b1, 32'd100, 32'd7);
    wait_done(0, 1'b0, lat1, bc);
    checks++;
    if (bus.zlo !== 32'd14) begin errors++; $display("FAIL b2b_first_zlo got %h want %h", bus.zlo, 32'd14); end
    launch(1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFB);
    wait_done(0, 1'b0, lat2, bc);
    checks += 3;
    if (lat2 + 1 !== 34) begin errors++; $display("FAIL b2b_spacing got %0d want 34", lat2 + 1); end
    if (bus.zlo !== 32'd25) begin errors++; $display("FAIL b2b_zlo got %h want %h", bus.zlo, 32'd25); end
    if (bus.zhi !== 32'd0) begin errors++; $display("FAIL b2b_zhi got %h want %h", bus.zhi, 32'd0); end
  endtask
  task automatic test_reset_mid;
    int lat, bc;
    logic saw_done;
    launch(1'b0, 32'd1000, 32'hFFFF_FC18);
    repeat (14) @(negedge clock);
    #2 clear = 1'b0;
    #1;
    checks += 5;
    if (bus.zhi !== 32'h0) begin errors++; $display("FAIL rstmid_zhi got %h want %h", bus.zhi, 32'h0); end
    if (bus.zlo !== 32'h0) begin errors++; $display("FAIL rstmid_zlo got %h want %h", bus.zlo, 32'h0); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", bus.done); end
    if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL rstmid_dz got %b want 0", bus.div_by_zero); end
    saw_done = 1'b0;
    repeat (2) @(negedge clock);
    clear = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      saw_done |= bus.done;
    end
    checks += 2;
    if (saw_done !== 1'b0) begin errors++; $display("FAIL rstmid_no_done got %b want 0", saw_done); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle got %b want 0", bus.busy); end
    launch(1'b0, 32'd1000, 32'hFFFF_FC18);
    wait_done(0, 1'b0, lat, bc);
    checks += 3;
    if (lat !== 33) begin errors++; $display("FAIL rstmid_new_latency got %0d want 33", lat); end
    if (bus.zhi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rstmid_new_zhi got %h want %h", bus.zhi, 32'hFFFF_FFFF); end
    if (bus.zlo !== 32'hFFF0_BDC0) begin errors++; $display("FAIL rstmid_new_zlo got %h want %h", bus.zlo, 32'hFFF0_BDC0); end
  endtask
  initial begin
    test_reset;
    test_mul;
    test_div;
    test_div_by_zero;
    test_ignore_start;
    test_operand_change;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
